// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream style bundle with master/slave modports
// Signals: tvalid/tready handshake, tdata payload, tstrb/tkeep byte qualifiers,
// tlast end of line, tuser start of frame, tid/tdest routing sideband.
interface axi4_stream_if #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
) ();
    logic                tvalid;
    logic                tready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tuser;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface

// File: rtl/rank_order_filter.sv
// rtl/rank_order_filter.sv - pipelined per-channel rank-order selector over a window
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   rank_i         requested rank (0 = min, N/2 = median, N-1 = max), latched at start of frame
//   en_i           1 = filter, 0 = bypass (centre pixel), latched at start of frame
//   video_i        window stream in: channel c, element k at bit (c*N+k)*PX_WIDTH
//   video_o        pixel stream out: channel c at bit c*PX_WIDTH, pad bits zero
//   active_rank_o  rank applied to the current frame
//   active_en_o    enable applied to the current frame
module rank_order_filter #(
    parameter int CHANNELS_AMOUNT = 3,
    parameter int PX_WIDTH        = 10,
    parameter int WIN_SIZE        = 3,
    parameter int RANK_W          = $clog2(WIN_SIZE * WIN_SIZE),
    parameter int ID_W            = 1,
    parameter int DEST_W          = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RANK_W-1:0] rank_i,
    input  logic              en_i,
    axi4_stream_if.slave      video_i,
    axi4_stream_if.master     video_o,
    output logic [RANK_W-1:0] active_rank_o,
    output logic              active_en_o
);
    localparam int N     = WIN_SIZE * WIN_SIZE;
    localparam int CH    = CHANNELS_AMOUNT;
    localparam int OUT_W = ((CH * PX_WIDTH + 7) / 8) * 8;
    localparam int OB    = OUT_W / 8;

    typedef logic [CH-1:0][N-1:0][PX_WIDTH-1:0] win_t;
    typedef logic [CH-1:0][N-1:0][N-1:0]        lt_t;
    typedef logic [CH-1:0][N-1:0][RANK_W:0]     rank_t;

    // Stream sideband carried beside the data through every stage.
    typedef struct packed {
        logic              user;
        logic              last;
        logic [OB-1:0]     strb;
        logic [OB-1:0]     keep;
        logic [ID_W-1:0]   id;
        logic [DEST_W-1:0] dest;
    } sb_t;

    logic              adv;
    logic              accept;
    logic [RANK_W-1:0] rank_sat;
    logic [RANK_W-1:0] snap_rank;
    logic              snap_en;
    win_t              in_x;
    sb_t               in_sb;
    lt_t               lt_next;
    rank_t             rank_next;
    logic [CH-1:0][PX_WIDTH-1:0] sel_next;

    logic              act_en_q, act_en_d;
    logic [RANK_W-1:0] act_rank_q, act_rank_d;

    logic              s1_valid_q, s1_valid_d;
    win_t              s1_x_q, s1_x_d;
    lt_t               s1_lt_q, s1_lt_d;
    sb_t               s1_sb_q, s1_sb_d;
    logic [RANK_W-1:0] s1_rank_q, s1_rank_d;
    logic              s1_en_q, s1_en_d;

    logic              s2_valid_q, s2_valid_d;
    win_t              s2_x_q, s2_x_d;
    rank_t             s2_r_q, s2_r_d;
    sb_t               s2_sb_q, s2_sb_d;
    logic [RANK_W-1:0] s2_rank_q, s2_rank_d;
    logic              s2_en_q, s2_en_d;

    logic              s3_valid_q, s3_valid_d;
    logic [OUT_W-1:0]  s3_data_q, s3_data_d;
    sb_t               s3_sb_q, s3_sb_d;

    logic unused_in;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign adv    = !s3_valid_q || video_o.tready;
    assign accept = video_i.tvalid && adv;

    assign in_x        = video_i.tdata[CH*N*PX_WIDTH-1:0];
    assign in_sb.user  = video_i.tuser;
    assign in_sb.last  = video_i.tlast;
    assign in_sb.strb  = video_i.tstrb[OB-1:0];
    assign in_sb.keep  = video_i.tkeep[OB-1:0];
    assign in_sb.id    = video_i.tid;
    assign in_sb.dest  = video_i.tdest;
    assign unused_in   = ^{video_i.tdata, video_i.tstrb, video_i.tkeep};

    assign rank_sat = (int'(rank_i) >= N) ? RANK_W'(N - 1) : rank_i;

    // Index tie-break makes every element's rank unique, so exactly one matches.
    always_comb begin
        lt_next = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    lt_next[c][i][j] = (in_x[c][j] < in_x[c][i]) ||
                                       ((in_x[c][j] == in_x[c][i]) && (j < i));
                end
            end
        end
    end

    always_comb begin
        rank_next = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    rank_next[c][i] = rank_next[c][i] + (RANK_W + 1)'(s1_lt_q[c][i][j]);
                end
            end
        end
    end

    always_comb begin
        sel_next = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < N; i++) begin
                sel_next[c] = sel_next[c] |
                    (s2_x_q[c][i] & {PX_WIDTH{s2_r_q[c][i] == {1'b0, s2_rank_q}}});
            end
            if (!s2_en_q) begin
                sel_next[c] = s2_x_q[c][N/2];
            end
        end
    end

    always_comb begin
        act_rank_d = act_rank_q;
        act_en_d   = act_en_q;
        snap_rank  = act_rank_q;
        snap_en    = act_en_q;
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_lt_d    = s1_lt_q;
        s1_sb_d    = s1_sb_q;
        s1_rank_d  = s1_rank_q;
        s1_en_d    = s1_en_q;
        s2_valid_d = s2_valid_q;
        s2_x_d     = s2_x_q;
        s2_r_d     = s2_r_q;
        s2_sb_d    = s2_sb_q;
        s2_rank_d  = s2_rank_q;
        s2_en_d    = s2_en_q;
        s3_valid_d = s3_valid_q;
        s3_data_d  = s3_data_q;
        s3_sb_d    = s3_sb_q;

        // A start-of-frame beat applies its own new control values.
        if (accept && video_i.tuser) begin
            act_rank_d = rank_sat;
            act_en_d   = en_i;
            snap_rank  = rank_sat;
            snap_en    = en_i;
        end

        if (adv) begin
            s1_valid_d = accept;
            s1_x_d     = in_x;
            s1_lt_d    = lt_next;
            s1_sb_d    = in_sb;
            s1_rank_d  = snap_rank;
            s1_en_d    = snap_en;

            s2_valid_d = s1_valid_q;
            s2_x_d     = s1_x_q;
            s2_r_d     = rank_next;
            s2_sb_d    = s1_sb_q;
            s2_rank_d  = s1_rank_q;
            s2_en_d    = s1_en_q;

            s3_valid_d = s2_valid_q;
            s3_data_d  = OUT_W'(sel_next);
            s3_sb_d    = s2_sb_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_rank_q <= RANK_W'(N / 2);
            act_en_q   <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_lt_q    <= '0;
            s1_sb_q    <= '0;
            s1_rank_q  <= '0;
            s1_en_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_r_q     <= '0;
            s2_sb_q    <= '0;
            s2_rank_q  <= '0;
            s2_en_q    <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_sb_q    <= '0;
        end else begin
            act_rank_q <= act_rank_d;
            act_en_q   <= act_en_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_lt_q    <= s1_lt_d;
            s1_sb_q    <= s1_sb_d;
            s1_rank_q  <= s1_rank_d;
            s1_en_q    <= s1_en_d;
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_r_q     <= s2_r_d;
            s2_sb_q    <= s2_sb_d;
            s2_rank_q  <= s2_rank_d;
            s2_en_q    <= s2_en_d;
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
            s3_sb_q    <= s3_sb_d;
        end
    end

    assign video_i.tready = adv;
    assign video_o.tvalid = s3_valid_q;
    assign video_o.tdata  = s3_data_q;
    assign video_o.tuser  = s3_sb_q.user;
    assign video_o.tlast  = s3_sb_q.last;
    assign video_o.tstrb  = s3_sb_q.strb;
    assign video_o.tkeep  = s3_sb_q.keep;
    assign video_o.tid    = s3_sb_q.id;
    assign video_o.tdest  = s3_sb_q.dest;
    assign active_rank_o  = act_rank_q;
    assign active_en_o    = act_en_q;
endmodule
